// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, funct3 codes and the access-legality check
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } dmem_state_t;

  // Unsigned variants exist only for loads; any store outside B/H/W is illegal.
  function automatic logic dmem_err(input logic we, input logic [2:0] funct3,
                                    input logic [1:0] addr_lo);
    logic bad_f3;
    logic misalign;
    bad_f3   = 1'b0;
    misalign = 1'b0;
    case (funct3)
      F3_B:    bad_f3 = 1'b0;
      F3_H:    misalign = addr_lo[0];
      F3_W:    misalign = |addr_lo;
      F3_BU:   bad_f3 = we;
      F3_HU: begin
        bad_f3   = we;
        misalign = addr_lo[0];
      end
      default: bad_f3 = 1'b1;
    endcase
    return bad_f3 | misalign;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way round-robin winner with last-grant memory
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_id = 1'b0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_q;
      default: gnt_id = 1'b0;
    endcase
    gnt    = (req == 2'b00) ? 2'b00 : (gnt_id ? 2'b10 : 2'b01);
    last_d = grant_en ? gnt_id : last_q;
  end

  // Reset to port 1 so that port 0 takes the first contended grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares data memory between CPU and debug ports
// Latches one request, drives memory for one cycle, responds two cycles after accept.
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  input  logic [2:0]  req_funct3_0,
  input  logic [2:0]  req_funct3_1,
  input  logic [1:0]  req_we,
  output logic [1:0]  resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [2:0]  mem_funct3,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  dmem_state_t state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic        port_q, port_d;
  logic        err_q, err_d;

  logic [1:0]  gnt;
  logic        gnt_id;
  logic        hs;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_funct3;
  logic        sel_we;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .grant_en (hs),
    .gnt      (gnt),
    .gnt_id   (gnt_id)
  );

  assign hs = (state_q == IDLE) && (|(req_valid & gnt));

  always_comb begin
    sel_addr   = gnt_id ? req_addr1    : req_addr0;
    sel_wdata  = gnt_id ? req_wdata1   : req_wdata0;
    sel_funct3 = gnt_id ? req_funct3_1 : req_funct3_0;
    sel_we     = req_we[gnt_id];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    port_d   = port_q;
    err_d    = err_q;
    if (hs) begin
      addr_d   = sel_addr;
      wdata_d  = sel_wdata;
      funct3_d = sel_funct3;
      we_d     = sel_we;
      port_d   = gnt_id;
      err_d    = dmem_err(sel_we, sel_funct3, sel_addr[1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      port_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      port_q   <= port_d;
      err_q    <= err_d;
    end
  end

  // mem_we decodes the state directly so an async reset removes it at once.
  always_comb begin
    req_ready  = 2'b00;
    mem_we     = 1'b0;
    resp_valid = 2'b00;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state_q)
      IDLE:  req_ready = gnt;
      ISSUE: mem_we = we_q & ~err_q;
      RESP: begin
        resp_valid = port_q ? 2'b10 : 2'b01;
        resp_err   = err_q;
        if (!we_q && !err_q) resp_rdata = mem_rd;
      end
      default: req_ready = 2'b00;
    endcase
  end

  assign mem_a      = addr_q;
  assign mem_wd     = wdata_q;
  assign mem_funct3 = funct3_q;

endmodule
